// File: rtl/io_port_responder.sv
// io_port_responder: I/O-bus responder for the core's IN/OUT instructions.
// Port 0x00 bridges console words through TX/RX FIFOs to valid/ready streams,
// port 0x01 reports FIFO status and port 0x02 is a prescaled 16-bit timer.
module io_port_responder #(
   parameter int unsigned TX_DEPTH = 4,
   parameter int unsigned RX_DEPTH = 4,
   parameter int unsigned PRESCALE = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        io_req,
   input  logic        io_we,
   input  logic [7:0]  io_addr,
   input  logic [15:0] io_wdata,
   output logic        io_ack,
   output logic [15:0] io_rdata,
   output logic        tx_valid,
   output logic [15:0] tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [15:0] rx_data,
   output logic        rx_ready
);

   localparam int unsigned TX_AW = $clog2(TX_DEPTH);
   localparam int unsigned RX_AW = $clog2(RX_DEPTH);
   localparam int unsigned PS_W  = $clog2(PRESCALE + 1);
   localparam logic [TX_AW:0]  TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
   localparam logic [RX_AW:0]  RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
   localparam logic [PS_W-1:0] PS_LAST     = PS_W'(PRESCALE - 1);

   typedef enum logic [1:0] {IDLE, WAIT_TX, ACK} state_t;
   state_t state;

   logic [15:0]      tx_mem [TX_DEPTH];
   logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [TX_AW:0]   tx_count;
   logic [15:0]      rx_mem [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [RX_AW:0]   rx_count;
   logic [15:0]      timer;
   logic [PS_W-1:0]  prescaler;

   logic        tx_full, rx_empty;
   logic        tx_push, tx_pop, rx_push, rx_pop, timer_load;
   logic [15:0] read_value;

   assign tx_full  = (tx_count == TX_FULL_CNT);
   assign rx_empty = (rx_count == '0);
   assign tx_valid = (tx_count != '0);
   assign tx_data  = tx_mem[tx_rd_ptr];
   assign rx_ready = (rx_count != RX_FULL_CNT);
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_push  = rx_valid & rx_ready;

   // Decode the current access into FIFO/timer side effects and the read value
   always_comb begin
      tx_push    = 1'b0;
      rx_pop     = 1'b0;
      timer_load = 1'b0;
      read_value = '0;
      case (state)
         IDLE: begin
            if (io_req) begin
               case (io_addr)
                  8'h00: begin
                     if (io_we) tx_push = !tx_full;
                     else       rx_pop  = !rx_empty;
                  end
                  8'h02:   timer_load = io_we;
                  default: ;
               endcase
            end
         end
         WAIT_TX: tx_push = !tx_full;
         default: ;
      endcase
      case (io_addr)
         8'h00:   read_value = rx_empty ? 16'h0000 : rx_mem[rx_rd_ptr];
         8'h01:   read_value = {14'b0, !tx_full, !rx_empty};
         8'h02:   read_value = timer;
         default: read_value = '0;
      endcase
   end

   // Access FSM with registered ack and read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         io_ack   <= 1'b0;
         io_rdata <= '0;
      end else begin
         io_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (io_req) begin
                  if (!io_we) io_rdata <= read_value;
                  if (io_we && io_addr == 8'h00 && tx_full) begin
                     state <= WAIT_TX;
                  end else begin
                     state  <= ACK;
                     io_ack <= 1'b1;
                  end
               end
            end
            WAIT_TX: begin
               if (!tx_full) begin
                  state  <= ACK;
                  io_ack <= 1'b1;
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO storage arrays (no reset needed; validity tracked by the counts)
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= io_wdata;
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
   end

   // TX FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: ;
         endcase
      end
   end

   // RX FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: ;
         endcase
      end
   end

   // Prescaled timer; a core write overrides a coincident increment and restarts the prescaler
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer     <= '0;
         prescaler <= '0;
      end else if (timer_load) begin
         timer     <= io_wdata;
         prescaler <= '0;
      end else if (prescaler == PS_LAST) begin
         timer     <= timer + 1'b1;
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder: directed steps plus randomized
// traffic, checked against queue-based FIFO models and an arithmetic timer model.
module tb_io_port_responder;

   localparam int TXD = 4;
   localparam int RXD = 4;
   localparam int PS  = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        io_req = 1'b0, io_we = 1'b0;
   logic [7:0]  io_addr = '0;
   logic [15:0] io_wdata = '0;
   logic        io_ack;
   logic [15:0] io_rdata;
   logic        tx_valid;
   logic [15:0] tx_data;
   logic        tx_ready = 1'b0;
   logic        rx_valid = 1'b0;
   logic [15:0] rx_data = '0;
   logic        rx_ready;

   io_port_responder #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .PRESCALE(PS)) dut (
      .clk(clk), .rst_n(rst_n), .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_ack(io_ack), .io_rdata(io_rdata), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [15:0] tx_q[$];
   logic [15:0] rx_q[$];
   logic        tx_pop_pend = 1'b0, tx_push_pend = 1'b0;
   logic        rx_pop_pend = 1'b0, rx_push_pend = 1'b0;
   logic [15:0] tx_push_data = '0, rx_push_data = '0;
   logic [15:0] last_rdata = '0;
   logic [15:0] t_base = '0;
   int          t_c0 = 0;
   int          cyc = 0;
   bit          rnd_en = 1'b0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Active edges since reset release; the timer model is derived from this
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Apply model events scheduled for this edge (pops from the head first)
   always @(posedge clk) begin
      if (rst_n) begin
         if (tx_pop_pend)  void'(tx_q.pop_front());
         if (tx_push_pend) tx_q.push_back(tx_push_data);
         if (rx_pop_pend)  void'(rx_q.pop_front());
         if (rx_push_pend) rx_q.push_back(rx_push_data);
      end
      tx_pop_pend  = 1'b0;
      tx_push_pend = 1'b0;
      rx_pop_pend  = 1'b0;
      rx_push_pend = 1'b0;
   end

   // Mid-cycle stream checks and stream handshake prediction
   always @(negedge clk) begin
      if (rst_n) begin
         chk("tx_valid", {15'b0, tx_valid}, {15'b0, tx_q.size() != 0});
         if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
         tx_pop_pend = (tx_q.size() != 0) && tx_ready;
         chk("rx_ready", {15'b0, rx_ready}, {15'b0, rx_q.size() != RXD});
         rx_push_pend = rx_valid && (rx_q.size() != RXD);
         rx_push_data = rx_data;
      end
   end

   // Random stream traffic while enabled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_en) begin
            tx_ready = 1'($urandom_range(0, 1));
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 16'($urandom);
         end
      end
   end

   // One complete core access; called at 1 time unit after a rising edge
   task automatic io_access(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                            input string tag);
      logic [15:0] exp;
      int n;
      exp = '0;
      n = 0;
      io_req = 1'b1;
      io_we = we;
      io_addr = addr;
      io_wdata = wdata;
      if (!we) begin
         case (addr)
            8'h00: if (rx_q.size() != 0) begin
               exp = rx_q[0];
               rx_pop_pend = 1'b1;
            end
            8'h01:   exp = {14'b0, tx_q.size() != TXD, rx_q.size() != 0};
            8'h02:   exp = t_base + 16'((cyc - t_c0) / PS);
            default: exp = '0;
         endcase
         last_rdata = exp;
      end else if (addr == 8'h02) begin
         t_base = wdata;
         t_c0 = cyc + 1;
      end
      if (we && addr == 8'h00) begin
         while (tx_q.size() == TXD && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            chk({tag, "_wait_noack"}, {15'b0, io_ack}, 16'h0000);
         end
         if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout observed=no_slot required=slot_within_300", tag);
         end
         tx_push_data = wdata;
         tx_push_pend = 1'b1;
      end
      @(posedge clk);
      #1;
      chk({tag, "_ack"}, {15'b0, io_ack}, 16'h0001);
      chk({tag, "_rdata"}, io_rdata, last_rdata);
      io_req = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_ack_low"}, {15'b0, io_ack}, 16'h0000);
   endtask

   task automatic reset_model();
      tx_q.delete();
      rx_q.delete();
      tx_pop_pend = 1'b0;
      tx_push_pend = 1'b0;
      rx_pop_pend = 1'b0;
      rx_push_pend = 1'b0;
      last_rdata = '0;
      t_base = '0;
      t_c0 = 0;
   endtask

   initial begin
      int n;
      logic [7:0] ra;
      // Reset
      rst_n = 1'b0;
      reset_model();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {15'b0, io_ack}, 16'h0000);
      chk("rst_rdata", io_rdata, 16'h0000);
      chk("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
      chk("rst_rx_ready", {15'b0, rx_ready}, 16'h0001);
      rst_n = 1'b1;
      io_access(1'b0, 8'h01, 16'h0, "status_reset");
      chk("status_reset_val", io_rdata, 16'h0002);

      // TX fill, blocking fifth write, single pop, drain order
      tx_ready = 1'b0;
      io_access(1'b1, 8'h00, 16'h1111, "tx1");
      io_access(1'b1, 8'h00, 16'h2222, "tx2");
      io_access(1'b1, 8'h00, 16'h3333, "tx3");
      io_access(1'b1, 8'h00, 16'h4444, "tx4");
      fork
         io_access(1'b1, 8'h00, 16'h5555, "tx5_blocked");
         begin
            repeat (3) @(posedge clk);
            #1;
            chk("tx_head_first", tx_data, 16'h1111);
            tx_ready = 1'b1;
            @(posedge clk);
            #1;
            tx_ready = 1'b0;
            chk("wait_ack_after_pop_edge", {15'b0, io_ack}, 16'h0000);
         end
      join
      tx_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      tx_ready = 1'b0;
      chk("tx_drained", {15'b0, tx_valid}, 16'h0000);

      // RX stream to core reads
      rx_valid = 1'b1;
      rx_data = 16'hABCD;
      @(posedge clk);
      #1;
      rx_data = 16'h1234;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
      io_access(1'b0, 8'h01, 16'h0, "status_rx2");
      chk("status_rx2_val", io_rdata, 16'h0003);
      io_access(1'b0, 8'h00, 16'h0, "rx_rd1");
      chk("rx_rd1_val", io_rdata, 16'hABCD);
      io_access(1'b0, 8'h00, 16'h0, "rx_rd2");
      chk("rx_rd2_val", io_rdata, 16'h1234);
      io_access(1'b0, 8'h00, 16'h0, "rx_rd_empty");
      chk("rx_rd_empty_val", io_rdata, 16'h0000);
      io_access(1'b0, 8'h01, 16'h0, "status_rx0");

      // RX full: pop does not open rx_ready in the same cycle
      rx_valid = 1'b1;
      for (int i = 0; i < RXD; i++) begin
         rx_data = 16'($urandom);
         @(posedge clk);
         #1;
      end
      rx_data = 16'h7777;
      @(posedge clk);
      #1;
      fork
         io_access(1'b0, 8'h00, 16'h0, "rx_full_pop");
         begin
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
         end
      join
      for (int i = 0; i < RXD; i++) io_access(1'b0, 8'h00, 16'h0, "rx_drain");
      chk("rx_last_7777", io_rdata, 16'h7777);

      // Timer wrap and write on an increment edge
      io_access(1'b1, 8'h02, 16'hFFFE, "tmr_load");
      repeat (32) @(posedge clk);
      #1;
      io_access(1'b0, 8'h02, 16'h0, "tmr_wrap");
      n = 0;
      while (((cyc + 1 - t_c0) % PS) != 0 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      io_access(1'b1, 8'h02, 16'h0100, "tmr_load_inc_edge");
      repeat (37) @(posedge clk);
      #1;
      io_access(1'b0, 8'h02, 16'h0, "tmr_after_load");
      io_access(1'b0, 8'h02, 16'h0, "tmr_after_load2");

      // Randomized traffic
      rnd_en = 1'b1;
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 4))
            0:       ra = 8'h00;
            1:       ra = 8'h01;
            2:       ra = 8'h02;
            3:       ra = 8'h00;
            default: ra = 8'($urandom);
         endcase
         io_access(1'($urandom_range(0, 1)), ra, 16'($urandom), "rnd");
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rnd_en = 1'b0;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      rx_valid = 1'b0;

      // Reset while a write is blocked in WAIT_TX
      n = 0;
      while (tx_q.size() < TXD && n < 10) begin
         io_access(1'b1, 8'h00, 16'($urandom), "tx_fill");
         n++;
      end
      io_req = 1'b1;
      io_we = 1'b1;
      io_addr = 8'h00;
      io_wdata = 16'hDEAD;
      @(posedge clk);
      #1;
      chk("blocked_noack1", {15'b0, io_ack}, 16'h0000);
      @(posedge clk);
      #1;
      chk("blocked_noack2", {15'b0, io_ack}, 16'h0000);
      rst_n = 1'b0;
      reset_model();
      #1;
      chk("rst_wait_tx_valid", {15'b0, tx_valid}, 16'h0000);
      chk("rst_wait_ack", {15'b0, io_ack}, 16'h0000);
      io_req = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_hold_ack", {15'b0, io_ack}, 16'h0000);
      rst_n = 1'b1;
      io_access(1'b0, 8'h01, 16'h0, "status_after_rst");
      chk("status_after_rst_val", io_rdata, 16'h0002);
      tx_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      tx_ready = 1'b0;
      chk("no_pending_emit", {15'b0, tx_valid}, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
